mem_burst_master: RTL and testbench

Bus initiator that drives the single-port word RAM peripheral's CPU-side interface: addr, write data, read data, write enable, read enable and ready. It accepts one command at a time from a control source (CPU register block or test sequencer) and executes word bursts: fill, copy, or read-checksum. It sits between the command source and the RAM peripheral, replacing direct CPU access during a burst.

---
 rtl/mem_burst_pkg.sv | 20 ++
 rtl/mem_burst_addr_gen.sv | 68 ++++++
 rtl/mem_burst_master.sv | 190 +++++++++++++++++++
 tb/tb_mem_burst_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared definitions for the memory burst master: op encodings, FSM states, word size.
// The optional checksum burst is enabled by defining MEM_BURST_SUM_EN.
package mem_burst_pkg;

    localparam logic [1:0] OP_FILL    = 2'b00;
    localparam logic [1:0] OP_COPY    = 2'b01;
    localparam logic [1:0] OP_SUM     = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_burst_addr_gen.sv
// Word-aligned source/destination pointers with wrapping +4 steps, plus the burst word counter.
// The *_d outputs are the values the pointers take at the next edge, so callers can register them.
module mem_burst_addr_gen
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_inc_src,
    input  logic              i_inc_dst,
    input  logic              i_inc_cnt,
    output logic [ADDR_W-1:0] o_src_d,
    output logic [ADDR_W-1:0] o_dst_d,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] w_src_d;
    logic [ADDR_W-1:0] w_dst_d;
    logic [LEN_W-1:0]  w_cnt_d;

    always_comb begin
        w_src_d = r_src;
        w_dst_d = r_dst;
        w_cnt_d = r_cnt;
        if (i_load) begin
            w_src_d = i_src & ALIGN_MASK;
            w_dst_d = i_dst & ALIGN_MASK;
            w_cnt_d = '0;
        end else begin
            // Plain modular add gives the 0xFFFC -> 0x0000 wrap for free.
            if (i_inc_src) w_src_d = r_src + STEP;
            if (i_inc_dst) w_dst_d = r_dst + STEP;
            if (i_inc_cnt) w_cnt_d = r_cnt + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src <= '0;
            r_dst <= '0;
            r_cnt <= '0;
            r_len <= '0;
        end else begin
            r_src <= w_src_d;
            r_dst <= w_dst_d;
            r_cnt <= w_cnt_d;
            if (i_load) r_len <= i_len;
        end
    end

    assign o_src_d = w_src_d;
    assign o_dst_d = w_dst_d;
    assign o_last  = ((r_cnt + LEN_W'(1)) == r_len);

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the single-port word RAM: fill, copy and (with MEM_BURST_SUM_EN) read-checksum.
// Handshake: a command is taken on cmd_valid && cmd_ready at posedge; a RAM access completes on mem_ready at posedge.
module mem_burst_master
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_fill,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum,
    output state_t            o_dbg_state
);

`ifdef MEM_BURST_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    state_t            r_state;
    state_t            w_state_d;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_mem_re;
    logic              r_done;
    logic              r_err;
    logic              w_accept;
    logic              w_illegal;
    logic              w_err_d;
    logic              w_inc_src;
    logic              w_inc_dst;
    logic              w_inc_cnt;
    logic              w_last;
    logic [ADDR_W-1:0] w_src_d;
    logic [ADDR_W-1:0] w_dst_d;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    assign w_illegal = (cmd_op == OP_ILLEGAL) || ((cmd_op == OP_SUM) && !SUM_EN);

    mem_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_accept),
        .i_src     (cmd_src),
        .i_dst     (cmd_dst),
        .i_len     (cmd_len),
        .i_inc_src (w_inc_src),
        .i_inc_dst (w_inc_dst),
        .i_inc_cnt (w_inc_cnt),
        .o_src_d   (w_src_d),
        .o_dst_d   (w_dst_d),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        w_err_d   = 1'b0;
        w_inc_src = 1'b0;
        w_inc_dst = 1'b0;
        w_inc_cnt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (w_illegal) begin
                        w_state_d = S_DONE;
                        w_err_d   = 1'b1;
                    end else if (cmd_len == '0) begin
                        w_state_d = S_DONE;
                    end else if (cmd_op == OP_FILL) begin
                        w_state_d = S_WRITE;
                    end else begin
                        w_state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (abort) begin
                    w_state_d = S_DONE;
                    w_err_d   = 1'b1;
                end else if (mem_ready) begin
                    w_inc_src = 1'b1;
                    w_state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                if (abort) begin
                    w_state_d = S_DONE;
                    w_err_d   = 1'b1;
                end else if (r_op == OP_COPY) begin
                    w_state_d = S_WRITE;
                end else begin
                    w_inc_cnt = 1'b1;
                    w_state_d = w_last ? S_DONE : S_READ;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_state_d = S_DONE;
                    w_err_d   = 1'b1;
                end else if (mem_ready) begin
                    w_inc_dst = 1'b1;
                    w_inc_cnt = 1'b1;
                    if (w_last)               w_state_d = S_DONE;
                    else if (r_op == OP_FILL) w_state_d = S_WRITE;
                    else                      w_state_d = S_READ;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // Bus outputs are loaded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= OP_FILL;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) r_op <= cmd_op;
            if (w_state_d == S_READ)       r_mem_addr <= w_src_d;
            else if (w_state_d == S_WRITE) r_mem_addr <= w_dst_d;
            // mem_wdata doubles as the copy holding register.
            if (w_state_d == S_WRITE && r_state == S_IDLE)      r_mem_wdata <= cmd_fill;
            else if (w_state_d == S_WRITE && r_state == S_CAPT) r_mem_wdata <= mem_rdata;
            r_mem_we <= (w_state_d == S_WRITE);
            r_mem_re <= (w_state_d == S_READ);
            r_done   <= (w_state_d == S_DONE);
            r_err    <= (w_state_d == S_DONE) && w_err_d;
        end
    end

`ifdef MEM_BURST_SUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                               r_checksum <= '0;
        else if (w_accept)                                          r_checksum <= '0;
        else if (r_state == S_CAPT && r_op == OP_SUM && !abort)     r_checksum <= r_checksum + mem_rdata;
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = r_mem_we;
    assign mem_re      = r_mem_re;
    assign done        = r_done;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural word RAM and a controllable mem_ready.
// Cycle k is the clock period that ends at edge k; the command is accepted at edge 0.
module tb_mem_burst_master;
    import mem_burst_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_src;
    logic [15:0] cmd_dst;
    logic [7:0]  cmd_len;
    logic [31:0] cmd_fill;
    logic        abort;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;
    state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [15:0] stall_addr_q[$];
    logic [31:0] stall_data_q[$];
    int          g_done_cyc;
    logic        g_err;
    int          g_re_cnt;
    int          g_both;
    int          g_ready_bad;
    state_t      g_abort_state;

    logic [31:0] ram [0:16383];

    always #5 clk = ~clk;

    mem_burst_master dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_len     (cmd_len),
        .cmd_fill    (cmd_fill),
        .abort       (abort),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .checksum    (checksum),
        .o_dbg_state (dbg_state)
    );

    always @(posedge clk) begin
        if (mem_we && mem_ready) ram[mem_addr[15:2]] <= mem_wdata;
        if (mem_re && mem_ready) mem_rdata <= ram[mem_addr[15:2]];
    end

    // Issues one command and monitors it until done or a 2000-cycle budget expires.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] src, input logic [15:0] dst,
                           input logic [7:0] len, input logic [31:0] fill, input int stall_idx,
                           input int stall_n, input int abort_cyc, input int busy_valid_cyc);
        int wr_cnt;
        int left;
        wr_addr_q.delete();
        wr_data_q.delete();
        stall_addr_q.delete();
        stall_data_q.delete();
        g_re_cnt = 0; g_both = 0; g_ready_bad = 0; g_done_cyc = -1; g_err = 1'b0;
        g_abort_state = S_IDLE;
        wr_cnt = 0; left = stall_n;
        @(negedge clk);
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill = fill;
        cmd_valid = 1'b1; mem_ready = 1'b1; abort = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            cmd_valid = (cyc <= busy_valid_cyc);
            if (cmd_valid) begin
                cmd_op = OP_FILL; cmd_dst = 16'h0200; cmd_len = 8'd1; cmd_fill = 32'h1234_5678;
                if (cmd_ready) g_ready_bad++;
            end
            abort = (cyc == abort_cyc);
            if (abort) g_abort_state = dbg_state;
            if (mem_we && wr_cnt == stall_idx && left > 0) begin
                mem_ready = 1'b0;
                left--;
                stall_addr_q.push_back(mem_addr);
                stall_data_q.push_back(mem_wdata);
            end else begin
                mem_ready = 1'b1;
            end
            if (mem_we && mem_re) g_both++;
            if (mem_we && mem_ready) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
                wr_cnt++;
            end
            if (mem_re && mem_ready) g_re_cnt++;
            if (done) begin
                g_done_cyc = cyc;
                g_err = err;
                break;
            end
        end
        cmd_valid = 1'b0; abort = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic preload(input logic [15:0] addr, input logic [31:0] data);
        run_cmd(OP_FILL, 16'h0, addr, 8'd1, data, -1, 0, 0, 0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_FILL; cmd_src = '0; cmd_dst = '0;
        cmd_len = '0; cmd_fill = '0; abort = 1'b0; mem_ready = 1'b1;
        #1;
        n_checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
        n_checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_en we=%b re=%b want 0/0", mem_we, mem_re); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b done=%b err=%b want 000", busy, done, err); end
        n_checks++; if (checksum !== 32'h0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_misc checksum=%h cmd_ready=%b want 0/1", checksum, cmd_ready); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill;
        run_cmd(OP_FILL, 16'h0, 16'h0010, 8'd4, 32'hA5A5_A5A5, -1, 0, 0, 0);
        n_checks++; if (g_done_cyc !== 5 || g_err !== 1'b0) begin n_fail++; $display("FAIL fill_done cyc=%0d err=%b want 5/0", g_done_cyc, g_err); end
        n_checks++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL fill_count got=%0d want 4", wr_addr_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_addr_q[i] !== 16'h0010 + 16'(4 * i) || wr_data_q[i] !== 32'hA5A5_A5A5) begin
                    n_fail++; $display("FAIL fill_word%0d addr=%h data=%h want %h/a5a5a5a5", i, wr_addr_q[i], wr_data_q[i], 16'h0010 + 16'(4 * i));
                end
            end
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL fill_after done=%b ready=%b busy=%b want 0/1/0", done, cmd_ready, busy); end
    endtask

    task automatic test_copy;
        for (int i = 0; i < 4; i++) preload(16'(4 * i), 32'(i + 1));
        run_cmd(OP_COPY, 16'h0000, 16'h0100, 8'd4, 32'h0, -1, 0, 0, 0);
        n_checks++; if (g_done_cyc !== 13 || g_err !== 1'b0) begin n_fail++; $display("FAIL copy_done cyc=%0d err=%b want 13/0", g_done_cyc, g_err); end
        n_checks++; if (g_re_cnt != 4 || wr_addr_q.size() != 4 || g_both != 0) begin n_fail++; $display("FAIL copy_access reads=%0d writes=%0d both=%0d want 4/4/0", g_re_cnt, wr_addr_q.size(), g_both); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ram[14'h40 + 14'(i)] !== 32'(i + 1)) begin n_fail++; $display("FAIL copy_ram%0d got=%h want %h", i, ram[14'h40 + 14'(i)], 32'(i + 1)); end
        end
    endtask

    task automatic test_sum;
        preload(16'h0000, 32'hFFFF_FFFF);
        preload(16'h0004, 32'h1);
        preload(16'h0008, 32'h2);
        preload(16'h000C, 32'h3);
        run_cmd(OP_SUM, 16'h0000, 16'h0, 8'd4, 32'h0, -1, 0, 0, 0);
`ifdef MEM_BURST_SUM_EN
        n_checks++; if (g_done_cyc !== 9 || g_err !== 1'b0) begin n_fail++; $display("FAIL sum_done cyc=%0d err=%b want 9/0", g_done_cyc, g_err); end
        n_checks++; if (checksum !== 32'h5 || g_re_cnt != 4) begin n_fail++; $display("FAIL sum_value checksum=%h reads=%0d want 00000005/4", checksum, g_re_cnt); end
`else
        n_checks++; if (g_done_cyc !== 1 || g_err !== 1'b1) begin n_fail++; $display("FAIL sum_disabled cyc=%0d err=%b want 1/1", g_done_cyc, g_err); end
        n_checks++; if (g_re_cnt != 0 || checksum !== 32'h0) begin n_fail++; $display("FAIL sum_noaccess reads=%0d checksum=%h want 0/0", g_re_cnt, checksum); end
`endif
    endtask

    task automatic test_degenerate;
        run_cmd(OP_FILL, 16'h0, 16'h0020, 8'd0, 32'h1, -1, 0, 0, 0);
        n_checks++; if (g_done_cyc !== 1 || g_err !== 1'b0 || wr_addr_q.size() != 0) begin n_fail++; $display("FAIL len0 cyc=%0d err=%b writes=%0d want 1/0/0", g_done_cyc, g_err, wr_addr_q.size()); end
        run_cmd(OP_ILLEGAL, 16'h0, 16'h0020, 8'd3, 32'h1, -1, 0, 0, 0);
        n_checks++; if (g_done_cyc !== 1 || g_err !== 1'b1) begin n_fail++; $display("FAIL illegal cyc=%0d err=%b want 1/1", g_done_cyc, g_err); end
        n_checks++; if (wr_addr_q.size() != 0 || g_re_cnt != 0) begin n_fail++; $display("FAIL illegal_access writes=%0d reads=%0d want 0/0", wr_addr_q.size(), g_re_cnt); end
    endtask

    task automatic test_stall_and_busy_cmd;
        preload(16'h0200, 32'hCAFE_0200);
        run_cmd(OP_FILL, 16'h0, 16'h0400, 8'd8, 32'h5A5A_0001, 2, 2, 0, 6);
        n_checks++; if (g_done_cyc !== 11 || g_err !== 1'b0) begin n_fail++; $display("FAIL stall_done cyc=%0d err=%b want 11/0", g_done_cyc, g_err); end
        n_checks++; if (stall_addr_q.size() != 2) begin n_fail++; $display("FAIL stall_count got=%0d want 2", stall_addr_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (stall_addr_q[i] !== 16'h0408 || stall_data_q[i] !== 32'h5A5A_0001) begin n_fail++; $display("FAIL stall_hold%0d addr=%h data=%h want 0408/5a5a0001", i, stall_addr_q[i], stall_data_q[i]); end
            end
        end
        n_checks++; if (wr_addr_q.size() != 8) begin n_fail++; $display("FAIL stall_writes got=%0d want 8", wr_addr_q.size()); end
        else if (wr_addr_q[7] !== 16'h041C) begin n_fail++; $display("FAIL stall_last addr=%h want 041c", wr_addr_q[7]); end
        n_checks++; if (g_ready_bad != 0) begin n_fail++; $display("FAIL busy_ready cmd_ready_while_busy=%0d want 0", g_ready_bad); end
        @(negedge clk);
        n_checks++; if (ram[14'h80] !== 32'hCAFE_0200) begin n_fail++; $display("FAIL busy_ignored ram200=%h want cafe0200", ram[14'h80]); end
    endtask

    task automatic test_abort;
        run_cmd(OP_FILL, 16'h0, 16'h0300, 8'd4, 32'hDEAD_BEEF, -1, 0, 0, 0);
        for (int i = 0; i < 4; i++) preload(16'h0040 + 16'(4 * i), 32'h7700 + 32'(i));
        run_cmd(OP_COPY, 16'h0040, 16'h0300, 8'd4, 32'h0, -1, 0, 5, 0);
        n_checks++; if (g_abort_state !== S_CAPT) begin n_fail++; $display("FAIL abort_state got=%0d want %0d", g_abort_state, S_CAPT); end
        n_checks++; if (g_done_cyc !== 6 || g_err !== 1'b1) begin n_fail++; $display("FAIL abort_done cyc=%0d err=%b want 6/1", g_done_cyc, g_err); end
        @(negedge clk);
        n_checks++; if (wr_addr_q.size() != 1 || ram[14'hC0] !== 32'h7700) begin n_fail++; $display("FAIL abort_word1 writes=%0d ram300=%h want 1/00007700", wr_addr_q.size(), ram[14'hC0]); end
        n_checks++; if (ram[14'hC1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL abort_word2 ram304=%h want deadbeef", ram[14'hC1]); end
    endtask

    task automatic test_wrap;
        run_cmd(OP_FILL, 16'h0, 16'hFFFA, 8'd3, 32'h0BAD_F00D, -1, 0, 0, 0);
        n_checks++; if (wr_addr_q.size() != 3) begin n_fail++; $display("FAIL wrap_count got=%0d want 3", wr_addr_q.size()); end
        else if (wr_addr_q[0] !== 16'hFFF8 || wr_addr_q[1] !== 16'hFFFC || wr_addr_q[2] !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_addr got=%h,%h,%h want fff8,fffc,0000", wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]);
        end
    endtask

    task automatic test_reset_mid;
        logic we_before;
        @(negedge clk);
        cmd_op = OP_FILL; cmd_dst = 16'h0800; cmd_len = 8'd8; cmd_fill = 32'h1111_2222; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 we_before = mem_we;
        reset_n = 1'b0;
        #1;
        n_checks++; if (we_before !== 1'b1) begin n_fail++; $display("FAIL midreset_pre we=%b want 1", we_before); end
        n_checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
            n_fail++; $display("FAIL midreset_bus addr=%h wdata=%h we=%b re=%b want 0/0/0/0", mem_addr, mem_wdata, mem_we, mem_re);
        end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_flags busy=%b done=%b err=%b ready=%b want 0/0/0/1", busy, done, err, cmd_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_sum();
        test_degenerate();
        test_stall_and_busy_cmd();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
